// File: rtl/osc_mix_sd.sv
// Oscillator mixer with slew-limited gain and first-order sigma-delta output.
// Define OSC_MIX_DITHER_EN to add LFSR dither into the modulator accumulator.
module osc_mix_sd #(
  parameter int N_OSC    = 8,
  parameter int VOL_BITS = 4,
  parameter int RAMP_DIV = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_OSC-1:0]    osc,
  input  logic [N_OSC-1:0]    osc_mask,
  input  logic [VOL_BITS-1:0] volume,
  input  logic                mute,
  output logic                snd,
  output logic                muted
);
  localparam int FS = N_OSC * ((1 << VOL_BITS) - 1);
  localparam int CW = $clog2(N_OSC + 1);
  localparam int AW = $clog2(2 * FS + 2);
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    MUTED = 2'd0,
    SLEW  = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [VOL_BITS-1:0] gain, gain_nxt, tgt;
  logic [PW-1:0]       presc, presc_nxt;
  logic [CW-1:0]       cnt, cnt_c;
  logic [AW-1:0]       lvl, acc, sum;
  logic                dith;

  assign tgt   = mute ? '0 : volume;
  assign muted = (state == MUTED);

  always_comb begin
    gain_nxt  = gain;
    presc_nxt = presc;
    if (gain == tgt) begin
      presc_nxt = '0;
    end else if (presc == PW'(RAMP_DIV - 1)) begin
      presc_nxt = '0;
      gain_nxt  = (gain < tgt) ? gain + VOL_BITS'(1) : gain - VOL_BITS'(1);
    end else begin
      presc_nxt = presc + PW'(1);
    end
  end

  // Transitions look at the post-step gain so state and gain change on the same edge.
  always_comb begin
    state_nxt = SLEW;
    if (state == MUTED && gain_nxt == '0)
      state_nxt = MUTED;
    else if (gain_nxt == '0 && mute)
      state_nxt = MUTED;
    else if (gain_nxt == tgt && !mute)
      state_nxt = PLAY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUTED;
      gain  <= '0;
      presc <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
      presc <= presc_nxt;
    end
  end

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < N_OSC; i++)
      cnt_c = cnt_c + CW'(osc[i] & ~osc_mask[i]);
  end

`ifdef OSC_MIX_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // No dither at full scale, otherwise acc could leave [0,FS-1].
  assign dith = (lvl < AW'(FS)) ? lfsr[0] : 1'b0;
`else
  assign dith = 1'b0;
`endif

  assign sum = acc + lvl + AW'(dith);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      lvl <= '0;
      acc <= '0;
      snd <= 1'b0;
    end else begin
      cnt <= cnt_c;
      lvl <= AW'(cnt) * AW'(gain);
      if (sum >= AW'(FS)) begin
        snd <= 1'b1;
        acc <= sum - AW'(FS);
      end else begin
        snd <= 1'b0;
        acc <= sum;
      end
    end
  end
endmodule

// File: tb/tb_osc_mix_sd.sv
// Directed bench for osc_mix_sd with N_OSC=8, VOL_BITS=4, RAMP_DIV=4 (FS=120).
module tb_osc_mix_sd;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] osc, osc_mask;
  logic [3:0] volume;
  logic       mute;
  logic       snd, muted;
  int         n_chk = 0;
  int         n_err = 0;

  osc_mix_sd #(.N_OSC(8), .VOL_BITS(4), .RAMP_DIV(4)) dut (
    .clk(clk), .reset(reset), .osc(osc), .osc_mask(osc_mask),
    .volume(volume), .mute(mute), .snd(snd), .muted(muted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic prev;
  int   ones;

  initial begin
    reset = 1'b1; osc = '0; osc_mask = '0; volume = 4'd15; mute = 1'b1;
    tick(2);
    chk("rst_muted", muted, 1);
    chk("rst_snd", snd, 0);
    chk("rst_gain", dut.gain, 0);
    chk("rst_state", dut.state, 0);
`ifdef OSC_MIX_DITHER_EN
    chk("lfsr_seed", dut.lfsr, 32'hACE1);
`endif

    // ramp up from reset
    reset = 1'b0; mute = 1'b0;
    tick(3);
    chk("up_muted_c3", muted, 1);
    tick(1);
    chk("up_muted_c4", muted, 0);
    chk("up_gain_c4", dut.gain, 1);
    tick(55);
    chk("up_gain_c59", dut.gain, 14);
    chk("up_state_c59", dut.state, 1);
    tick(1);
    chk("up_gain_c60", dut.gain, 15);
    chk("up_state_c60", dut.state, 2);

`ifdef OSC_MIX_DITHER_EN
    osc = 8'h0F;
    tick(4);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      tick(1);
      if (snd) ones++;
    end
    chk("dith_density", (ones >= 2008 && ones <= 2088), 1);
`else
    // full scale and silence with latency
    osc = 8'hFF;
    tick(2);
    chk("fs_latency", snd, 0);
    tick(1);
    chk("fs_first", snd, 1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("fs_const", snd, 1);
    end
    osc = 8'h00;
    tick(2);
    chk("zero_latency", snd, 1);
    tick(1);
    chk("zero_first", snd, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("zero_const", snd, 0);
    end

    // half scale from acc=0
    osc = 8'h0F;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("half_pattern", snd, i % 2);
    end

    // masked upper oscillators give the same level
    osc = 8'hFF; osc_mask = 8'hF0;
    prev = snd;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("mask_alt", snd, !prev);
      prev = snd;
    end

    // ramp down on mute
    mute = 1'b1;
    tick(59);
    chk("dn_muted_c59", muted, 0);
    chk("dn_gain_c59", dut.gain, 1);
    tick(1);
    chk("dn_muted_c60", muted, 1);
    chk("dn_gain_c60", dut.gain, 0);
    tick(3);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("dn_silent", snd, 0);
    end

    // reset mid-ramp
    osc = 8'hFF; osc_mask = 8'h00; mute = 1'b0;
    tick(28);
    chk("mid_gain7", dut.gain, 7);
    reset = 1'b1; osc = 8'h00;
    tick(1);
    chk("mid_rst_gain", dut.gain, 0);
    chk("mid_rst_muted", muted, 1);
    chk("mid_rst_snd", snd, 0);
    chk("mid_rst_state", dut.state, 0);
    reset = 1'b0;
    tick(3);
    chk("re_muted_c3", muted, 1);
    tick(1);
    chk("re_muted_c4", muted, 0);
    tick(56);
    chk("re_state_play", dut.state, 2);
    osc = 8'h0F;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("re_half_pattern", snd, i % 2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
